// File: rtl/vga_window_ctrl_pkg.sv
// vga_pkg: shared types and constants for the windowed VGA controller.
//   vga_seg_t / vga_timing_t : sum-of-segments timing description
//   VGA_640X480_60           : default 640x480@60 timing
//   segTotal()               : total length of one timing axis
//   region_e                 : per-pixel region (BLANK, BORDER, WINDOW)
//   pix_tag_t                : per-pixel flags carried through the delay line
//   barColour()              : colour-bar index to 24-bit RGB
package vga_pkg;

  typedef struct packed {
    int unsigned act;
    int unsigned fp;
    int unsigned sw;
    int unsigned bp;
  } vga_seg_t;

  typedef struct packed {
    vga_seg_t h;
    vga_seg_t v;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h: '{act: 640, fp: 16, sw: 96, bp: 48},
    v: '{act: 480, fp: 10, sw: 2,  bp: 33}
  };

  function automatic int unsigned segTotal(vga_seg_t s);
    return s.sw + s.bp + s.act + s.fp;
  endfunction

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    BORDER = 2'd1,
    WINDOW = 2'd2
  } region_e;

  // Flags sampled in the counter cycle and replayed REQ_LEAD cycles later,
  // alongside the source data for the same pixel.
  typedef struct packed {
    logic    hSyncOn;
    logic    vSyncOn;
    region_e region;
    logic [2:0] bar;
    logic    testMode;
  } pix_tag_t;

  // Bar index bit2 = red, bit1 = green, bit0 = blue, each fully on or off.
  function automatic logic [23:0] barColour(logic [2:0] idx);
    return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
  endfunction

endpackage

// File: rtl/vga_window_ctrl_if.sv
// vga_window_ctrl_if: pixel-fetch bus between the controller and its source.
//   oReq           : window pixel request (controller -> source)
//   oReqX / oReqY  : window-relative coordinate of the request, CW bits
//   iRed/iGreen/iBlue : pixel data returned REQ_LEAD cycles after oReq
// master = controller side, slave = pixel source side.
interface vga_window_ctrl_if #(
  parameter int unsigned CW = 11
) ();
  logic          oReq;
  logic [CW-1:0] oReqX;
  logic [CW-1:0] oReqY;
  logic [7:0]    iRed;
  logic [7:0]    iGreen;
  logic [7:0]    iBlue;

  modport master (
    output oReq, oReqX, oReqY,
    input  iRed, iGreen, iBlue
  );

  modport slave (
    input  oReq, oReqX, oReqY,
    output iRed, iGreen, iBlue
  );
endinterface

// File: rtl/vga_window_ctrl_delay_line.sv
// vga_delay_line: WIDTH x DEPTH shift register, asynchronously cleared.
//   iCLK   : clock
//   iRST_N : asynchronous active-low reset, clears every stage to 0
//   iData  : word entering the line
//   oData  : word that entered DEPTH clocks earlier
module vga_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oData
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= iData;
      for (int unsigned i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign oData = stages[DEPTH-1];

endmodule

// File: rtl/vga_window_ctrl.sv
// vga_window_ctrl: parametrised VGA timing generator with windowed pixel fetch.
//   iCLK / iRST_N    : pixel clock, asynchronous active-low reset
//   iTestPattern     : colour bars instead of window data, latched per frame
//   pix (master)     : oReq/oReqX/oReqY request, iRed/iGreen/iBlue data
//   oFrameStart      : high while H_Cont = V_Cont = 0
//   H_Cont / V_Cont  : raw timing counters (sync, back porch, active, front porch)
//   oVGA_R/G/B       : registered colour, REQ_LEAD+1 cycles behind the counters
//   oVGA_H/V_SYNC    : registered syncs, active level H_POL / V_POL
//   oVGA_BLANK       : registered, 1 = active video
//   oVGA_SYNC        : tied 0;  oVGA_CLK : iCLK passed through
module vga_window_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT      = VGA_640X480_60.h.act,
  parameter int unsigned H_FP       = VGA_640X480_60.h.fp,
  parameter int unsigned H_SW       = VGA_640X480_60.h.sw,
  parameter int unsigned H_BP       = VGA_640X480_60.h.bp,
  parameter int unsigned V_ACT      = VGA_640X480_60.v.act,
  parameter int unsigned V_FP       = VGA_640X480_60.v.fp,
  parameter int unsigned V_SW       = VGA_640X480_60.v.sw,
  parameter int unsigned V_BP       = VGA_640X480_60.v.bp,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned WIN_X0     = 64,
  parameter int unsigned WIN_Y0     = 0,
  parameter int unsigned WIN_W      = 512,
  parameter int unsigned WIN_H      = 480,
  parameter int unsigned REQ_LEAD   = 2,
  parameter logic [23:0] BORDER_RGB = 24'h000000,
  parameter int unsigned CW         = 11
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iTestPattern,
  vga_window_ctrl_if.master pix,
  output logic          oFrameStart,
  output logic [CW-1:0] H_Cont,
  output logic [CW-1:0] V_Cont,
  output logic [7:0]    oVGA_R,
  output logic [7:0]    oVGA_G,
  output logic [7:0]    oVGA_B,
  output logic          oVGA_H_SYNC,
  output logic          oVGA_V_SYNC,
  output logic          oVGA_BLANK,
  output logic          oVGA_SYNC,
  output logic          oVGA_CLK
);

  localparam vga_timing_t TIM = '{
    h: '{act: H_ACT, fp: H_FP, sw: H_SW, bp: H_BP},
    v: '{act: V_ACT, fp: V_FP, sw: V_SW, bp: V_BP}
  };
  localparam int unsigned H_TOT = segTotal(TIM.h);
  localparam int unsigned V_TOT = segTotal(TIM.v);
  localparam int unsigned TAG_W = $bits(pix_tag_t);

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_SW);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_SW);
  localparam logic [CW-1:0] H_ACT_BEG  = CW'(H_SW + H_BP);
  localparam logic [CW-1:0] V_ACT_BEG  = CW'(V_SW + V_BP);
  localparam logic [CW-1:0] H_ACT_LEN  = CW'(H_ACT);
  localparam logic [CW-1:0] V_ACT_LEN  = CW'(V_ACT);
  localparam logic [CW-1:0] WX0        = CW'(WIN_X0);
  localparam logic [CW-1:0] WY0        = CW'(WIN_Y0);
  localparam logic [CW-1:0] WW         = CW'(WIN_W);
  localparam logic [CW-1:0] WH         = CW'(WIN_H);
  localparam logic [CW-1:0] BAR_W      = CW'(H_ACT / 8);

  if (REQ_LEAD < 1 || REQ_LEAD > 4) begin : gBadLead
    $error("vga_window_ctrl: REQ_LEAD must be in 1..4");
  end

  // Timing counters
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      H_Cont <= '0;
      V_Cont <= '0;
    end else if (H_Cont == H_LAST) begin
      H_Cont <= '0;
      V_Cont <= (V_Cont == V_LAST) ? '0 : V_Cont + 1'b1;
    end else begin
      H_Cont <= H_Cont + 1'b1;
    end
  end

  assign oFrameStart = (H_Cont == '0) && (V_Cont == '0);

  // Region decode. Each "lo <= x < lo+len" test is done as one unsigned
  // compare of (x - lo) against len: positions below lo wrap to values larger
  // than any legal len, so no separate lower-bound compare is needed.
  logic [CW-1:0] hRel, vRel, reqX, reqY;
  logic          hAct, vAct, inWin;

  assign hRel  = H_Cont - H_ACT_BEG;
  assign vRel  = V_Cont - V_ACT_BEG;
  assign hAct  = hRel < H_ACT_LEN;
  assign vAct  = vRel < V_ACT_LEN;
  assign reqX  = hRel - WX0;
  assign reqY  = vRel - WY0;
  assign inWin = hAct && vAct && (reqX < WW) && (reqY < WH);

  assign pix.oReq  = inWin;
  assign pix.oReqX = inWin ? reqX : '0;
  assign pix.oReqY = inWin ? reqY : '0;

  // Test mode only changes on a frame boundary.
  logic testMode;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)          testMode <= 1'b0;
    else if (oFrameStart) testMode <= iTestPattern;
  end

  pix_tag_t tagNow, tagOut;
  logic [TAG_W-1:0] tagOutBits;

  always_comb begin
    tagNow          = '0;
    tagNow.hSyncOn  = H_Cont < H_SYNC_END;
    tagNow.vSyncOn  = V_Cont < V_SYNC_END;
    tagNow.bar      = 3'(hRel / BAR_W);
    tagNow.testMode = testMode;
    if (!(hAct && vAct)) tagNow.region = BLANK;
    else if (inWin)      tagNow.region = WINDOW;
    else                 tagNow.region = BORDER;
  end

  vga_delay_line #(
    .WIDTH (TAG_W),
    .DEPTH (REQ_LEAD)
  ) uTagDelay (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iData  (tagNow),
    .oData  (tagOutBits)
  );

  assign tagOut = pix_tag_t'(tagOutBits);

  // The delayed tag lines up with the source data for the same pixel.
  logic [23:0] pixColour;
  always_comb begin
    pixColour = '0;
    if (tagOut.region != BLANK) begin
      if (tagOut.testMode)               pixColour = barColour(tagOut.bar);
      else if (tagOut.region == WINDOW)  pixColour = {pix.iRed, pix.iGreen, pix.iBlue};
      else                               pixColour = BORDER_RGB;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      {oVGA_R, oVGA_G, oVGA_B} <= '0;
      oVGA_BLANK               <= 1'b0;
      oVGA_H_SYNC              <= ~H_POL;
      oVGA_V_SYNC              <= ~V_POL;
    end else begin
      {oVGA_R, oVGA_G, oVGA_B} <= pixColour;
      oVGA_BLANK               <= tagOut.region != BLANK;
      oVGA_H_SYNC              <= tagOut.hSyncOn ? H_POL : ~H_POL;
      oVGA_V_SYNC              <= tagOut.vSyncOn ? V_POL : ~V_POL;
    end
  end

  assign oVGA_SYNC = 1'b0;
  assign oVGA_CLK  = iCLK;

endmodule

// File: tb/tb_vga_window_ctrl.sv
// Bench for vga_window_ctrl: two reduced-timing configurations run side by side
// against a position-from-cycle-count reference model.
//   cfg 0 : REQ_LEAD=2, bordered window, active-low syncs, non-zero border
//   cfg 1 : REQ_LEAD=4, full-screen window, active-high syncs
module tb_vga_window_ctrl;
  import vga_pkg::*;

  localparam int unsigned CW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  for (genvar k = 0; k < 2; k++) begin : gCfg
    localparam int HA = 64, HF = 4, HS = 8, HB = 6;
    localparam int VA = 24, VF = 2, VS = 2, VB = 3;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FRAME = HT * VT;
    localparam bit HP = (k == 1);
    localparam bit VP = (k == 1);
    localparam int WX0  = (k == 0) ? 8  : 0;
    localparam int WW   = (k == 0) ? 40 : HA;
    localparam int WY0  = (k == 0) ? 4  : 0;
    localparam int WH   = (k == 0) ? 16 : VA;
    localparam int LEAD = (k == 0) ? 2  : 4;
    localparam logic [23:0] BORDER = (k == 0) ? 24'h123456 : 24'hA5C3E7;
    localparam int RST_AT = FRAME + 12 * HT + 40;

    logic rstN, tp, frameStart;
    logic [CW-1:0] hCont, vCont;
    logic [7:0] r, g, b;
    logic hs, vs, blank, sync, vclk;

    vga_window_ctrl_if #(.CW(CW)) pix ();

    vga_window_ctrl #(
      .H_ACT(HA), .H_FP(HF), .H_SW(HS), .H_BP(HB),
      .V_ACT(VA), .V_FP(VF), .V_SW(VS), .V_BP(VB),
      .H_POL(HP), .V_POL(VP),
      .WIN_X0(WX0), .WIN_Y0(WY0), .WIN_W(WW), .WIN_H(WH),
      .REQ_LEAD(LEAD), .BORDER_RGB(BORDER), .CW(CW)
    ) dut (
      .iCLK(clk), .iRST_N(rstN), .iTestPattern(tp), .pix(pix),
      .oFrameStart(frameStart), .H_Cont(hCont), .V_Cont(vCont),
      .oVGA_R(r), .oVGA_G(g), .oVGA_B(b),
      .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_BLANK(blank),
      .oVGA_SYNC(sync), .oVGA_CLK(vclk)
    );

    logic [23:0] reqData [16];
    bit tpAt [8];

    function automatic bit activeAt(int p);
      int h, v;
      h = p % HT;
      v = (p / HT) % VT;
      return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    endfunction

    function automatic bit winAt(int p);
      int x, y;
      x = (p % HT) - HS - HB - WX0;
      y = ((p / HT) % VT) - VS - VB - WY0;
      return activeAt(p) && (x >= 0) && (x < WW) && (y >= 0) && (y < WH);
    endfunction

    initial begin : run
      int n, m, p, h, v, x, y, ph, pv, idx;
      bit didReset, win, eHs, eVs, eBlank;
      logic [23:0] eRgb;

      rstN = 1'b0;
      tp = 1'b0;
      {pix.iRed, pix.iGreen, pix.iBlue} = '0;
      repeat (3) @(posedge clk);
      #1 rstN = 1'b1;
      n = 0;
      didReset = 1'b0;

      while (!(didReset && n > 3 * FRAME + 50)) begin
        h = n % HT;
        v = (n / HT) % VT;
        x = h - HS - HB - WX0;
        y = v - VS - VB - WY0;
        win = winAt(n);

        tp = 1'($urandom_range(0, 1));
        if (h == 0 && v == 0) tpAt[(n / FRAME) % 8] = tp;
        if (win) reqData[n % 16] = 24'($urandom());
        m = n - LEAD;
        if (m >= 0 && winAt(m)) {pix.iRed, pix.iGreen, pix.iBlue} = reqData[m % 16];
        else                    {pix.iRed, pix.iGreen, pix.iBlue} = 24'($urandom());

        chk("hcont", hCont, h);
        chk("vcont", vCont, v);
        chk("framestart", frameStart, (h == 0 && v == 0));
        chk("req", pix.oReq, win);
        chk("reqx", pix.oReqX, win ? x : 0);
        chk("reqy", pix.oReqY, win ? y : 0);
        chk("vgasync", sync, 0);

        p = n - LEAD - 1;
        if (p < 0) begin
          eRgb = '0; eBlank = 1'b0; eHs = !HP; eVs = !VP;
        end else begin
          ph = p % HT;
          pv = (p / HT) % VT;
          eHs = (ph < HS) ? HP : !HP;
          eVs = (pv < VS) ? VP : !VP;
          eBlank = activeAt(p);
          if (!eBlank) eRgb = '0;
          else if (tpAt[(p / FRAME) % 8]) begin
            idx = (ph - HS - HB) / (HA / 8);
            eRgb = {((idx & 4) != 0) ? 8'hFF : 8'h00,
                    ((idx & 2) != 0) ? 8'hFF : 8'h00,
                    ((idx & 1) != 0) ? 8'hFF : 8'h00};
          end
          else if (winAt(p)) eRgb = reqData[p % 16];
          else eRgb = BORDER;
        end
        chk("rgb", {r, g, b}, eRgb);
        chk("hsync", hs, eHs);
        chk("vsync", vs, eVs);
        chk("blank", blank, eBlank);

        if (!didReset && n == RST_AT) begin
          #1 rstN = 1'b0;
          #1;
          chk("rst_hcont", hCont, 0);
          chk("rst_vcont", vCont, 0);
          chk("rst_rgb", {r, g, b}, 0);
          chk("rst_blank", blank, 0);
          chk("rst_hsync", hs, !HP);
          chk("rst_vsync", vs, !VP);
          chk("rst_req", pix.oReq, 0);
          chk("rst_framestart", frameStart, 1);
          didReset = 1'b1;
          repeat (2) @(posedge clk);
          #1 rstN = 1'b1;
          n = 0;
        end else begin
          @(posedge clk);
          #1;
          n++;
        end
      end
      done[k] = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 50000; t++) begin
      if (done[0] && done[1]) break;
      @(posedge clk);
    end
    chk("timeout", (done[0] && done[1]), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_window_ctrl.md
# vga_window_ctrl

Parametrised VGA timing generator and pixel-fetch front end; successor to the fixed 640x480 controller in the Filter-GPU display path. It generates sync, blank and counters from a sum-of-segments timing model. It issues per-pixel read requests with (X, Y) for an image window placed anywhere inside the active area, and absorbs a fixed source latency. It paints a configurable border colour outside the window and offers a frame-latched colour-bar test mode.

## Interface
- H_ACT, 640, active pixels per line
- H_FP / H_SW / H_BP, 16 / 96 / 48, horizontal front porch / sync width / back porch
- V_ACT, 480, active lines
- V_FP / V_SW / V_BP, 10 / 2 / 33, vertical front porch / sync width / back porch
- H_POL / V_POL, 0 / 0, sync active level (0 = active-low)
- WIN_X0 / WIN_Y0, 64 / 0, window origin relative to first active pixel/line
- WIN_W / WIN_H, 512 / 480, window size; WIN_X0+WIN_W ≤ H_ACT, WIN_Y0+WIN_H ≤ V_ACT
- REQ_LEAD, 2, source latency in cycles from oReq to valid iRed/iGreen/iBlue; legal 1..4
- BORDER_RGB, 24'h000000, colour for active-but-outside-window pixels
- CW, 11, counter and coordinate width
- iCLK  in  1  pixel clock
- iRST_N  in  1  reset; one clock, reset asynchronous and active-low
- iTestPattern  in  1  1 = colour bars instead of window data
- iRed / iGreen / iBlue  in  8 each  pixel data, valid REQ_LEAD cycles after matching oReq
- oReq  out  1  window pixel request (combinational from counters)
- oReqX / oReqY  out  CW each  window-relative coordinate of request; 0 when oReq=0
- oFrameStart  out  1  one-cycle pulse when H_Cont=0 and V_Cont=0
- H_Cont / V_Cont  out  CW each  raw timing counters
- oVGA_R / oVGA_G / oVGA_B  out  8 each  registered colour
- oVGA_H_SYNC / oVGA_V_SYNC  out  1 each  registered syncs, polarity per H_POL/V_POL
- oVGA_BLANK  out  1  registered, 1 = active video
- oVGA_SYNC  out  1  constant 0
- oVGA_CLK  out  1  = iCLK

## Operation
- Line segment order from H_Cont=0: sync, back porch, active, front porch; H_TOT=H_SW+H_BP+H_ACT+H_FP (800 default). Same for vertical (525).
- H_Cont counts 0..H_TOT-1 then wraps to 0. V_Cont advances on every H wrap and itself wraps at V_TOT-1 to 0 simultaneously with H.
- Active: H_Cont in [H_SW+H_BP, H_SW+H_BP+H_ACT), likewise vertical. Window: active and relative coords inside [WIN_X0, WIN_X0+WIN_W) × [WIN_Y0, WIN_Y0+WIN_H).
- oReq=1 exactly in window cycles; oReqX/oReqY = relative coord − WIN_X0/WIN_Y0, widths CW, no overflow by the parameter legality rule.
- Colour select, at the output register: not active → 0; active, test mode → bar colour; active outside window → BORDER_RGB; window → iRed/iGreen/iBlue.
- Test bars: 8 bars of H_ACT/8 pixels, colour index = bar number, bit2=R, bit1=G, bit0=B, each 8'hFF or 8'h00.
- iTestPattern is sampled only in the oFrameStart cycle; a change mid-frame takes effect from the next frame.
- Reset (asynchronous, any time, including mid-line): counters 0, oVGA_R/G/B 0, oVGA_BLANK 0, syncs at inactive level, delay line cleared, test mode 0. The first cycle after release is H_Cont=0, V_Cont=0 with oFrameStart=1.

## Timing
- Counter-domain signals (oReq, oReqX/Y, oFrameStart, H_Cont, V_Cont) are combinational and same-cycle.
- Every oVGA_* output for counter position (h,v) appears REQ_LEAD+1 cycles after the cycle where the counters equal (h,v). Sync, blank and region flags pass through a REQ_LEAD-deep delay line, then the output register.
- Source data is captured on the edge ending cycle t+REQ_LEAD for the request issued in cycle t. No backpressure; the source must meet the latency.

## Structure
- Package vga_pkg: timing-parameter struct, 640x480@60 defaults, bar colour constant function, region enum (BLANK, BORDER, WINDOW).
- Sub-module vga_delay_line (parametrised width × depth shift register, async reset to 0), used for sync/blank/region alignment.

## Test plan
- Defaults, reset release → H_Cont wraps 799→0. V_Cont wraps 524→0 in the same cycle. oFrameStart period 420000 cycles.
- H_Cont=0..95 → oVGA_H_SYNC=0 from cycle 3 to 98, since latency = REQ_LEAD+1 = 3. V sync is low for lines 0–1.
- Source returns X[7:0] on R with latency 2 → first window pixel at H_Cont=208, V_Cont=35 gives oReqX=0. oVGA_R=0 appears 3 cycles later. Pixels at H_Cont 144..207 show BORDER_RGB.
- iTestPattern raised at V_Cont=100 → current frame unchanged. Next frame, H_Cont=144+80 gives oVGA_R/G/B = 00/00/FF, 3 cycles later.
- iRST_N pulsed low at H_Cont=400, V_Cont=200 → all outputs reset immediately, asynchronously. Restart at (0,0) with oFrameStart=1.
- REQ_LEAD=4, WIN_X0=0, WIN_W=H_ACT → no border pixels. Data aligns at 5-cycle latency.
